// File: rtl/uart_tx_cfg_if.sv
// Bus between a transmit client and uart_tx_cfg.
//   txbyte    : payload to send, LSB first (DATA_BITS wide)
//   senddata  : transmit request, sampled on every rising clk edge while idle
//   txdone    : high while the transmitter is idle and will accept a request
//   tx        : serial line, idle high
//   dbg_state : current FSM state encoding (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// Handshake: a frame is accepted on any rising edge where txdone=1 and
// senddata=1; txdone falls at that same edge and stays low until the final
// stop bit has been held for its full period.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] txbyte;
    logic                 senddata;
    logic                 txdone;
    logic                 tx;
    logic [2:0]           dbg_state;

    modport master (
        output txbyte, senddata,
        input  txdone, tx, dbg_state
    );

    modport slave (
        input  txbyte, senddata,
        output txdone, tx, dbg_state
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter.
//   clk : sole clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : uart_tx_cfg_if slave modport (txbyte, senddata in; txdone, tx,
//         dbg_state out)
// Frame: start(0), DATA_BITS payload bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit is held CLKS_PER_BIT clk cycles.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_cfg_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Counts data bits in DATA and stop bits in STOP.
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 period_end;

    assign period_end    = (cnt_q == CNT_LAST);
    assign bus.tx        = tx_q;
    assign bus.txdone    = done_q;
    assign bus.dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the level the line takes at the coming edge, so each state
    // computes the value of the *next* bit when its own period ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = done_q;

        if (state_q != ST_IDLE) begin
            cnt_d = period_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                done_d = 1'b1;
                cnt_d  = '0;
                bit_d  = '0;
                if (bus.senddata) begin
                    shift_d = bus.txbyte;
                    // Parity is fixed at accept time from the full payload.
                    par_d   = (PARITY == 1) ? ~(^bus.txbyte) : (^bus.txbyte);
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    done_d  = 1'b0;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (period_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (period_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg. Four instances share clk/rst, all with
// CLKS_PER_BIT=4: u0 8N1, u1 8E1, u2 8O1, u3 7N2.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] send  = 4'b0000;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic [6:0] data3 = 7'h00;
    wire  [3:0] tx_w;
    wire  [3:0] done_w;

    int checks   = 0;
    int failures = 0;

    uart_tx_cfg_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) bus3 ();

    assign bus0.txbyte = data0;
    assign bus1.txbyte = data1;
    assign bus2.txbyte = data2;
    assign bus3.txbyte = data3;
    assign bus0.senddata = send[0];
    assign bus1.senddata = send[1];
    assign bus2.senddata = send[2];
    assign bus3.senddata = send[3];
    assign tx_w   = {bus3.tx, bus2.tx, bus1.tx, bus0.tx};
    assign done_w = {bus3.txdone, bus2.txdone, bus1.txdone, bus0.txdone};

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB))
        u2 (.clk(clk), .rst(rst), .bus(bus2));
    uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB))
        u3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after send[idx] has been raised while idle.
    // exp_bits holds the frame line levels, bit 0 = start bit.
    // Every cycle of the frame must show the expected tx level with txdone
    // low; the cycle after the frame must show the idle line with txdone high.
    task automatic run_frame(input int idx, input int nbits, input logic [15:0] exp_bits,
                             input bit pulse, input bit poke, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (pulse && b == 0 && c == 0) send[idx] = 1'b0;
                if (poke && b == 3 && c == 0) begin
                    send[idx] = 1'b1;
                    data0     = 8'h00;
                end
                if (poke && b == 3 && c == 1) send[idx] = 1'b0;
                chk($sformatf("%s_tx_bit%0d_cyc%0d", tag, b, c), {15'd0, tx_w[idx]}, {15'd0, exp_bits[b]});
                chk($sformatf("%s_txdone_bit%0d_cyc%0d", tag, b, c), {15'd0, done_w[idx]}, 16'd0);
            end
        end
        @(negedge clk);
        chk($sformatf("%s_end_txdone", tag), {15'd0, done_w[idx]}, 16'd1);
        chk($sformatf("%s_end_tx", tag), {15'd0, tx_w[idx]}, 16'd1);
    endtask

    task automatic check_idle(input int idx, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_idle_tx_%0d", tag, i), {15'd0, tx_w[idx]}, 16'd1);
            chk($sformatf("%s_idle_txdone_%0d", tag, i), {15'd0, done_w[idx]}, 16'd1);
        end
    endtask

    initial begin
        // Reset state on all instances while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_tx", {12'd0, tx_w}, 16'h000F);
        chk("rst_txdone", {12'd0, done_w}, 16'h000F);
        chk("rst_state0", {13'd0, bus0.dbg_state}, 16'd0);
        rst = 1'b0;
        check_idle(0, 3, "post_rst");

        // 8N1 0xA5: frame {stop, A5, start} = 0x34A -> 0,1,0,1,0,0,1,0,1,1.
        data0   = 8'hA5;
        send[0] = 1'b1;
        run_frame(0, 10, 16'h034A, 1'b1, 1'b0, "a5_8n1");
        check_idle(0, 2, "a5_after");

        // 8E1 0x55: four ones -> parity 0. Frame {1, 0, 55, 0} = 0x4AA.
        data1   = 8'h55;
        send[1] = 1'b1;
        run_frame(1, 11, 16'h04AA, 1'b1, 1'b0, "55_even");

        // 8O1 0x55: parity 1. Frame {1, 1, 55, 0} = 0x6AA.
        data2   = 8'h55;
        send[2] = 1'b1;
        run_frame(2, 11, 16'h06AA, 1'b1, 1'b0, "55_odd");

        // 7N2 0x7F: {1, 1, 7F, 0} = 0x3FE, ten bit periods.
        data3   = 7'h7F;
        send[3] = 1'b1;
        run_frame(3, 10, 16'h03FE, 1'b1, 1'b0, "7f_7n2");

        // 0xFF frame with a new request and payload 0x00 during DATA:
        // still sends 0xFF and no second frame follows.
        data0   = 8'hFF;
        send[0] = 1'b1;
        run_frame(0, 10, 16'h03FE, 1'b1, 1'b1, "ff_poke");
        check_idle(0, 12, "ff_poke_after");

        // senddata held for two back-to-back frames: one idle cycle between.
        data0   = 8'hA5;
        send[0] = 1'b1;
        run_frame(0, 10, 16'h034A, 1'b0, 1'b0, "hold_f1");
        run_frame(0, 10, 16'h034A, 1'b0, 1'b0, "hold_f2");
        send[0] = 1'b0;
        check_idle(0, 4, "hold_after");

        // Reset during DATA of a 0x00 frame: line returns high with no edge.
        data0   = 8'h00;
        send[0] = 1'b1;
        @(negedge clk);
        send[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_state_data", {13'd0, bus0.dbg_state}, 16'd2);
        chk("mid_tx_low", {15'd0, tx_w[0]}, 16'd0);
        chk("mid_txdone_low", {15'd0, done_w[0]}, 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", {15'd0, tx_w[0]}, 16'd1);
        chk("async_rst_txdone", {15'd0, done_w[0]}, 16'd1);
        chk("async_rst_state", {13'd0, bus0.dbg_state}, 16'd0);
        @(negedge clk);
        rst     = 1'b0;
        data0   = 8'hA5;
        send[0] = 1'b1;
        run_frame(0, 10, 16'h034A, 1'b1, 1'b0, "after_rst");
        check_idle(0, 2, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload width, legal 5..9.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bit count, legal 1 or 2.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal >= 2.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port txbyte  input  DATA_BITS  payload to send, LSB first.
REQ-008 SHALL have port senddata  input  1  transmit request, level-sampled.
REQ-009 SHALL have port txdone  output  1  high when idle and ready to accept.
REQ-010 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL hold every non-IDLE state bit for exactly CLKS_PER_BIT clk cycles, timed by an internal counter of width $clog2(CLKS_PER_BIT).
REQ-013 In IDLE, senddata=1 at a rising edge SHALL latch txbyte into a shift buffer, enter START, and drive tx=0 and txdone=0 from that edge on.
REQ-014 In IDLE with senddata=0, the block SHALL hold tx=1 and txdone=1.
REQ-015 START SHALL last one bit period, then enter DATA.
REQ-016 DATA SHALL shift out DATA_BITS bits LSB first, one per bit period, counted by a bit counter.
REQ-017 After the last data bit, the block SHALL enter PARITY if PARITY!=0, otherwise STOP.
REQ-018 The PARITY bit SHALL be the XOR of the latched payload for even parity and its inverse for odd parity, so that the total count of ones including parity is even or odd respectively.
REQ-019 STOP SHALL drive tx=1 for STOP_BITS bit periods, then enter IDLE with txdone=1 at the same edge.
REQ-020 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, measured from the accepting edge to the edge where txdone rises.
REQ-021 senddata and txbyte changes while not in IDLE SHALL be ignored; the latched payload SHALL NOT change mid-frame.
REQ-022 With senddata held high, the next frame SHALL start at the first edge after txdone rises, giving exactly one idle clk cycle with tx=1 between frames.
REQ-023 tx SHALL be driven from a register (glitch-free), never combinationally from the FSM.
REQ-024 Illegal parameter values SHALL fail elaboration.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force state=IDLE, tx=1, txdone=1, and clear the bit counter, the cycle counter and the shift buffer.
REQ-026 Asserting rst mid-frame SHALL abort the frame immediately, with no partial stop bit, and the block SHALL accept a new request on the first edge after rst deasserts.

Verification
REQ-027 CLKS_PER_BIT=4, 8N1, txbyte=0xA5, senddata pulse -> tx = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; txdone low for 40 cycles.
REQ-028 PARITY=2, txbyte=0x55 -> parity bit 0; PARITY=1, same byte -> parity bit 1; frame length 11 bit periods.
REQ-029 DATA_BITS=7, STOP_BITS=2, txbyte=0x7F -> start, seven 1s, two stop 1s; txdone low for 10*CLKS_PER_BIT cycles.
REQ-030 senddata pulsed and txbyte changed to 0x00 during DATA of a 0xFF frame -> frame completes as 0xFF and no second frame follows.
REQ-031 senddata held high for two frames -> exactly one idle-high cycle between the last stop bit and the second start bit.
REQ-032 rst asserted during the DATA state -> tx=1 and txdone=1 without waiting for a clk edge; a fresh request after release transmits a correct full frame.
